bus_arbiter: RTL and testbench
==============================

# bus_arbiter

Two-requester round-robin arbiter and sequencer for the 16-bit local register bus (baddr/bwr/bstrobe/bwrdata/brddata). It replaces direct single-master drive of the bus so that the PS mailbox FSM and the serial-link command engine can both issue reads and writes. It generates the same setup-then-strobe bus cycle the zreg/zror registers expect. Each transfer is returned to its requester as registered read data plus a one-cycle ack.

## Interface
- SETUP_WAIT, default 0: extra cycles (0–15) that baddr/bwr are held on the bus before bstrobe.
- clk  in  1  bus clock; all logic on its rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- req0, req1  in  1 each  request level from requester 0 and requester 1.
- wr0, wr1  in  1 each  1 = write, 0 = read; valid while the matching req is high.
- addr0, addr1  in  16 each  target bus address.
- wrdata0, wrdata1  in  16 each  write data.
- ack0, ack1  out  1 each  one-cycle pulse when that requester's transfer completes.
- rddata0, rddata1  out  16 each  registered read result for that requester.
- baddr  out  16  bus address.
- bwrdata  out  16  bus write data.
- bwr  out  1  bus write enable.
- bstrobe  out  1  bus strobe.
- brddata  in  16  bus read data, combinational from the register slaves.
- grant  out  2  one-hot owner of the bus; 00 when idle.
- busy  out  1  high in any state other than IDLE.
- nops0, nops1  out  16 each  count of transfers completed per requester; wraps.

## Operation
- States: IDLE, SETUP, STROBE, DONE.
- IDLE:
  - If any req is high, pick a winner.
  - When both req are high, the winner is the requester not served last. last_grant resets to 1, so requester 0 wins the first tie.
  - On grant, latch the winner's wr, addr and wrdata into baddr, bwrdata and the internal wr flag. Set grant, load the wait counter with SETUP_WAIT, and go to SETUP.
- SETUP:
  - baddr and bwrdata are valid. bwr equals the latched wr flag. bstrobe = 0.
  - Decrement the counter. Go to STROBE when it reads 0.
- STROBE:
  - bstrobe = 1 for exactly one cycle. bwr stays at the latched flag.
  - For a read, capture brddata into the winner's rddata at the end of this cycle.
  - Go to DONE.
- DONE:
  - The winner's ack = 1. bwr = 0, bstrobe = 0.
  - Increment the winner's nops. Update last_grant. Clear grant. Go to IDLE.
- Requester's responsibility:
  - Hold req, wr, addr and wrdata stable until ack.
  - Drop req in the cycle after ack, unless it wants another transfer.
  - A req that is still high in IDLE after ack counts as a new request.
- Inputs are sampled only at grant. If req drops mid-transfer, the transfer still completes and ack still pulses.
- A write leaves rddata unchanged. rddata for each requester holds until that requester's next read.
- The nops counters wrap 0xFFFF → 0x0000 with no flag.
- Reset values: state IDLE; baddr, bwrdata, rddata0/1, nops0/1 = 0; bwr, bstrobe, ack0/1, busy = 0; grant = 00; last_grant = 1.
- Reset asserted mid-transfer:
  - Abort on the next edge and drive the reset values.
  - No ack is issued and the aborted transfer is not remembered.
  - If a strobe was in flight, it is dropped.

## Timing
- req sampled high in IDLE at edge t. Then:
  - SETUP begins in cycle t+1.
  - STROBE occurs in cycle t+2+SETUP_WAIT.
  - ack and valid rddata appear in cycle t+3+SETUP_WAIT.
- Bus setup time: baddr/bwr are stable 1+SETUP_WAIT cycles before bstrobe and remain stable through the strobe cycle.
- Back-to-back operation: after DONE there is always one IDLE cycle. Minimum transfer period is 4+SETUP_WAIT cycles.
- When both requesters are continuously active, grants strictly alternate. Neither requester waits more than one transfer.
- A requester that asserts req in the same cycle the other is granted waits for that transfer to finish and is served next.
- All outputs are registered. There is no combinational path from req to any bus signal.

## Test plan
- Reset, then a single read: req0 = 1, wr0 = 0, addr0 = 0x0001 with the slave returning 0xBEEF, SETUP_WAIT = 0 → bstrobe high in cycle t+2, ack0 high in cycle t+3, rddata0 = 0xBEEF, nops0 = 1, grant returns to 00.
- Write then readback: req1 writes 0x1234 to 0x0003, then reads 0x0003 → exactly one bwr & bstrobe cycle at 0x0003, ack1 pulses twice, rddata1 = 0x1234, rddata1 unchanged after the write alone.
- Contention: req0 and req1 both asserted in the same cycle and held through 4 transfers → grant order 0, 1, 0, 1; each ack spaced 4 cycles apart; nops0 = nops1 = 2.
- SETUP_WAIT = 3: single read → baddr stable 4 cycles before bstrobe, ack at t+6.
- Reset mid-transfer: rst_n = 0 during STROBE → next cycle bstrobe = 0, grant = 00, no ack, nops unchanged; with req still high, a fresh transfer starts after rst_n = 1.
- Wrap: preload nops0 = 0xFFFF via 65535 transfers (or force) → one more transfer gives nops0 = 0x0000 with nops1 unaffected.

Source files
------------

// File: rtl/bus_arbiter.sv
// Round-robin arbiter and sequencer that lets two requesters share the local register bus.
// A transfer takes 4+SETUP_WAIT cycles from grant to idle. Losers wait while req is held, and inputs are sampled only at grant.
module bus_arbiter #(
  parameter int unsigned SETUP_WAIT = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        req1,
  input  logic        wr0,
  input  logic        wr1,
  input  logic [15:0] addr0,
  input  logic [15:0] addr1,
  input  logic [15:0] wrdata0,
  input  logic [15:0] wrdata1,
  output logic        ack0,
  output logic        ack1,
  output logic [15:0] rddata0,
  output logic [15:0] rddata1,
  output logic [15:0] baddr,
  output logic [15:0] bwrdata,
  output logic        bwr,
  output logic        bstrobe,
  input  logic [15:0] brddata,
  output logic [1:0]  grant,
  output logic        busy,
  output logic [15:0] nops0,
  output logic [15:0] nops1
);

  localparam logic [3:0] LP_WAIT = 4'(SETUP_WAIT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_DONE
  } state_t;

  state_t      r_state;
  logic        r_last;
  logic        r_own;
  logic [3:0]  r_cnt;
  logic [15:0] r_baddr;
  logic [15:0] r_bwrdata;
  logic        r_bwr;
  logic        r_bstrobe;
  logic [15:0] r_rd0;
  logic [15:0] r_rd1;
  logic        r_ack0;
  logic        r_ack1;
  logic [15:0] r_nops0;
  logic [15:0] r_nops1;
  logic [1:0]  r_grant;
  logic        r_busy;

  logic        w_any;
  logic        w_win;

  // On a tie the requester that was not served last wins.
  assign w_any = req0 | req1;
  assign w_win = (req0 & req1) ? ~r_last : (req1 & ~req0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_last    <= 1'b1;
      r_own     <= 1'b0;
      r_cnt     <= 4'd0;
      r_baddr   <= 16'h0000;
      r_bwrdata <= 16'h0000;
      r_bwr     <= 1'b0;
      r_bstrobe <= 1'b0;
      r_rd0     <= 16'h0000;
      r_rd1     <= 16'h0000;
      r_ack0    <= 1'b0;
      r_ack1    <= 1'b0;
      r_nops0   <= 16'h0000;
      r_nops1   <= 16'h0000;
      r_grant   <= 2'b00;
      r_busy    <= 1'b0;
    end else begin
      r_ack0 <= 1'b0;
      r_ack1 <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_own     <= w_win;
            r_bwr     <= w_win ? wr1 : wr0;
            r_baddr   <= w_win ? addr1 : addr0;
            r_bwrdata <= w_win ? wrdata1 : wrdata0;
            r_grant   <= w_win ? 2'b10 : 2'b01;
            r_cnt     <= LP_WAIT;
            r_busy    <= 1'b1;
            r_state   <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (r_cnt == 4'd0) begin
            r_bstrobe <= 1'b1;
            r_state   <= S_STROBE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_STROBE: begin
          // r_bwr still holds the latched direction here; it is dropped for DONE.
          r_bstrobe <= 1'b0;
          r_bwr     <= 1'b0;
          if (!r_bwr) begin
            if (r_own) r_rd1 <= brddata;
            else       r_rd0 <= brddata;
          end
          if (r_own) begin
            r_ack1  <= 1'b1;
            r_nops1 <= r_nops1 + 16'd1;
          end else begin
            r_ack0  <= 1'b1;
            r_nops0 <= r_nops0 + 16'd1;
          end
          r_last  <= r_own;
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_grant <= 2'b00;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ack0    = r_ack0;
  assign ack1    = r_ack1;
  assign rddata0 = r_rd0;
  assign rddata1 = r_rd1;
  assign baddr   = r_baddr;
  assign bwrdata = r_bwrdata;
  assign bwr     = r_bwr;
  assign bstrobe = r_bstrobe;
  assign grant   = r_grant;
  assign busy    = r_busy;
  assign nops0   = r_nops0;
  assign nops1   = r_nops1;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: two instances (SETUP_WAIT 0 and 3) share one stimulus stream,
// each checked every cycle against a transaction-level model plus directed literal checks.
module tb_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, req1, wr0, wr1;
  logic [15:0] addr0, addr1, wd0, wd1;
  logic        preload;
  logic        cmp_en;

  logic        ack0_o [2];
  logic        ack1_o [2];
  logic [15:0] rd0_o  [2];
  logic [15:0] rd1_o  [2];
  logic [15:0] baddr_o[2];
  logic [15:0] bwd_o  [2];
  logic        bwr_o  [2];
  logic        bstr_o [2];
  logic [15:0] brd_i  [2];
  logic [1:0]  grant_o[2];
  logic        busy_o [2];
  logic [15:0] nops0_o[2];
  logic [15:0] nops1_o[2];

  logic [15:0] sm [2][16];

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  bus_arbiter #(.SETUP_WAIT(0)) u0 (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
    .addr0(addr0), .addr1(addr1), .wrdata0(wd0), .wrdata1(wd1),
    .ack0(ack0_o[0]), .ack1(ack1_o[0]), .rddata0(rd0_o[0]), .rddata1(rd1_o[0]),
    .baddr(baddr_o[0]), .bwrdata(bwd_o[0]), .bwr(bwr_o[0]), .bstrobe(bstr_o[0]),
    .brddata(brd_i[0]), .grant(grant_o[0]), .busy(busy_o[0]),
    .nops0(nops0_o[0]), .nops1(nops1_o[0])
  );

  bus_arbiter #(.SETUP_WAIT(3)) u1 (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
    .addr0(addr0), .addr1(addr1), .wrdata0(wd0), .wrdata1(wd1),
    .ack0(ack0_o[1]), .ack1(ack1_o[1]), .rddata0(rd0_o[1]), .rddata1(rd1_o[1]),
    .baddr(baddr_o[1]), .bwrdata(bwd_o[1]), .bwr(bwr_o[1]), .bstrobe(bstr_o[1]),
    .brddata(brd_i[1]), .grant(grant_o[1]), .busy(busy_o[1]),
    .nops0(nops0_o[1]), .nops1(nops1_o[1])
  );

  function automatic int wt(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  function automatic logic [15:0] memv(input int i);
    return (i == 1) ? 16'hBEEF : 16'hA000 + 16'(i) * 16'h0111;
  endfunction

  // Register slaves: combinational read, write on a strobed write cycle.
  assign brd_i[0] = sm[0][baddr_o[0][3:0]];
  assign brd_i[1] = sm[1][baddr_o[1][3:0]];

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        for (int i = 0; i < 16; i++) sm[d][i] <= memv(i);
      end else if (bwr_o[d] && bstr_o[d]) begin
        sm[d][baddr_o[d][3:0]] <= bwd_o[d];
      end
    end
  end

  // Transaction model: a grant starts a transfer, and everything else follows from
  // the number of edges elapsed since that grant.
  int          m_act [2];
  int          m_k   [2];
  int          m_own [2];
  int          m_last[2];
  logic        m_wr  [2];
  logic [15:0] m_addr[2];
  logic [15:0] m_wd  [2];
  logic [15:0] m_rd  [2][2];
  logic [15:0] m_nops[2][2];
  logic [15:0] mm    [2][16];

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        m_act[d] = 0; m_k[d] = 0; m_own[d] = 0; m_last[d] = 1;
        m_wr[d] = 1'b0; m_addr[d] = 16'h0; m_wd[d] = 16'h0;
        for (int r = 0; r < 2; r++) begin
          m_rd[d][r] = 16'h0;
          m_nops[d][r] = 16'h0;
        end
        for (int i = 0; i < 16; i++) mm[d][i] = memv(i);
      end else if (m_act[d] != 0) begin
        m_k[d] = m_k[d] + 1;
        if (m_k[d] == wt(d) + 2) begin
          if (m_wr[d]) mm[d][m_addr[d][3:0]] = m_wd[d];
          else         m_rd[d][m_own[d]] = mm[d][m_addr[d][3:0]];
          m_nops[d][m_own[d]] = m_nops[d][m_own[d]] + 16'd1;
          m_last[d] = m_own[d];
        end else if (m_k[d] == wt(d) + 3) begin
          m_act[d] = 0;
        end
      end else if (req0 || req1) begin
        m_own[d]  = (req0 && req1) ? ((m_last[d] == 0) ? 1 : 0) : (req1 ? 1 : 0);
        m_wr[d]   = (m_own[d] == 1) ? wr1 : wr0;
        m_addr[d] = (m_own[d] == 1) ? addr1 : addr0;
        m_wd[d]   = (m_own[d] == 1) ? wd1 : wd0;
        m_act[d]  = 1;
        m_k[d]    = 0;
      end
      if (d == 0 && preload && rst_n) m_nops[0][0] = 16'hFFFF;
    end
  end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int d = 0; d < 2; d++) begin
        logic       a;
        logic [1:0] eg;
        a  = (m_act[d] != 0);
        eg = a ? ((m_own[d] == 1) ? 2'b10 : 2'b01) : 2'b00;
        chk($sformatf("d%0d_grant", d), 16'(grant_o[d]), 16'(eg));
        chk($sformatf("d%0d_busy", d), 16'(busy_o[d]), 16'(a));
        chk($sformatf("d%0d_bstrobe", d), 16'(bstr_o[d]), 16'(a && m_k[d] == wt(d) + 1));
        chk($sformatf("d%0d_bwr", d), 16'(bwr_o[d]), 16'(a && m_k[d] <= wt(d) + 1 && m_wr[d]));
        chk($sformatf("d%0d_ack0", d), 16'(ack0_o[d]), 16'(a && m_k[d] == wt(d) + 2 && m_own[d] == 0));
        chk($sformatf("d%0d_ack1", d), 16'(ack1_o[d]), 16'(a && m_k[d] == wt(d) + 2 && m_own[d] == 1));
        chk($sformatf("d%0d_baddr", d), baddr_o[d], m_addr[d]);
        chk($sformatf("d%0d_bwrdata", d), bwd_o[d], m_wd[d]);
        chk($sformatf("d%0d_rddata0", d), rd0_o[d], m_rd[d][0]);
        chk($sformatf("d%0d_rddata1", d), rd1_o[d], m_rd[d][1]);
        chk($sformatf("d%0d_nops0", d), nops0_o[d], m_nops[d][0]);
        chk($sformatf("d%0d_nops1", d), nops1_o[d], m_nops[d][1]);
      end
    end
  end

  // Waits up to budget cycles for a condition on the SETUP_WAIT=0 instance.
  task automatic wait_u0(input int sel, input int budget, input string nm);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(negedge clk);
      case (sel)
        0:       hit = ack0_o[0];
        1:       hit = ack1_o[0];
        default: hit = bstr_o[0];
      endcase
    end
    chk(nm, 16'(hit), 16'd1);
  endtask

  initial begin
    int n_ack1, n_wstb, nacks;
    int order [4];
    int acyc  [4];

    rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; wr0 = 1'b0; wr1 = 1'b0;
    addr0 = 16'h0; addr1 = 16'h0; wd0 = 16'h0; wd1 = 16'h0;
    preload = 1'b0; cmp_en = 1'b0;
    order = '{0, 0, 0, 0};
    acyc  = '{0, 0, 0, 0};

    repeat (2) @(negedge clk);
    cmp_en = 1'b1;
    chk("rst_grant", 16'(grant_o[0]), 16'h0);
    chk("rst_busy", 16'(busy_o[0]), 16'h0);
    chk("rst_bstrobe", 16'(bstr_o[0]), 16'h0);
    chk("rst_nops0", nops0_o[0], 16'h0);
    chk("rst_rddata0", rd0_o[0], 16'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single read of 0x0001 (slave holds 0xBEEF) on both instances.
    req0 = 1'b1; wr0 = 1'b0; addr0 = 16'h0001;
    @(negedge clk);
    chk("rd_t1_bstrobe", 16'(bstr_o[0]), 16'h0);
    chk("rd_t1_grant", 16'(grant_o[0]), 16'h1);
    chk("w3_t1_baddr", baddr_o[1], 16'h0001);
    @(negedge clk);
    chk("rd_t2_bstrobe", 16'(bstr_o[0]), 16'h1);
    chk("w3_t2_bstrobe", 16'(bstr_o[1]), 16'h0);
    @(negedge clk);
    chk("rd_t3_ack0", 16'(ack0_o[0]), 16'h1);
    chk("rd_t3_rddata0", rd0_o[0], 16'hBEEF);
    chk("rd_t3_nops0", nops0_o[0], 16'h1);
    req0 = 1'b0;
    @(negedge clk);
    chk("rd_t4_grant", 16'(grant_o[0]), 16'h0);
    chk("w3_t4_bstrobe", 16'(bstr_o[1]), 16'h0);
    chk("w3_t4_baddr", baddr_o[1], 16'h0001);
    @(negedge clk);
    chk("w3_t5_bstrobe", 16'(bstr_o[1]), 16'h1);
    chk("w3_t5_baddr", baddr_o[1], 16'h0001);
    @(negedge clk);
    chk("w3_t6_ack0", 16'(ack0_o[1]), 16'h1);
    chk("w3_t6_rddata0", rd0_o[1], 16'hBEEF);
    repeat (4) @(negedge clk);

    // Requester 1: write 0x1234 to 0x0003, then read it back.
    req1 = 1'b1; wr1 = 1'b1; addr1 = 16'h0003; wd1 = 16'h1234;
    n_ack1 = 0; n_wstb = 0;
    for (int i = 0; i < 40 && n_ack1 < 2; i++) begin
      @(negedge clk);
      if (bwr_o[0] && bstr_o[0] && baddr_o[0] == 16'h0003) n_wstb++;
      if (ack1_o[0]) begin
        n_ack1++;
        if (n_ack1 == 1) begin
          chk("wr_rddata1_held", rd1_o[0], 16'h0);
          wr1 = 1'b0;
        end else begin
          req1 = 1'b0;
        end
      end
    end
    req1 = 1'b0;
    chk("wrrd_ack1_count", 16'(n_ack1), 16'd2);
    chk("wrrd_write_strobes", 16'(n_wstb), 16'd1);
    chk("wrrd_rddata1", rd1_o[0], 16'h1234);
    repeat (14) @(negedge clk);

    // Contention: both held through four transfers.
    req0 = 1'b1; wr0 = 1'b0; addr0 = 16'h0001;
    req1 = 1'b1; wr1 = 1'b0; addr1 = 16'h0003;
    nacks = 0;
    for (int i = 0; i < 60 && nacks < 4; i++) begin
      @(negedge clk);
      if (ack0_o[0] || ack1_o[0]) begin
        order[nacks] = ack1_o[0] ? 1 : 0;
        acyc[nacks]  = i;
        nacks++;
        if (nacks == 4) begin
          req0 = 1'b0;
          req1 = 1'b0;
        end
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    chk("cont_nacks", 16'(nacks), 16'd4);
    for (int j = 0; j < 4; j++) chk($sformatf("cont_order%0d", j), 16'(order[j]), 16'(j % 2));
    for (int j = 1; j < 4; j++) chk($sformatf("cont_spacing%0d", j), 16'(acyc[j] - acyc[j-1]), 16'd4);
    chk("cont_nops0", nops0_o[0], 16'd3);
    chk("cont_nops1", nops1_o[0], 16'd4);
    repeat (14) @(negedge clk);

    // Reset during the strobe cycle, then a fresh transfer with req still high.
    req0 = 1'b1; wr0 = 1'b0; addr0 = 16'h0001;
    wait_u0(2, 10, "mid_rst_strobe_seen");
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_bstrobe", 16'(bstr_o[0]), 16'h0);
    chk("mid_rst_grant", 16'(grant_o[0]), 16'h0);
    chk("mid_rst_ack0", 16'(ack0_o[0]), 16'h0);
    chk("mid_rst_nops0", nops0_o[0], 16'h0);
    rst_n = 1'b1;
    wait_u0(0, 12, "post_rst_ack0");
    chk("post_rst_nops0", nops0_o[0], 16'd1);
    req0 = 1'b0;
    repeat (12) @(negedge clk);

    // Counter wrap: preload nops0 to 0xFFFF, then one more transfer.
    @(posedge clk);
    #1;
    cmp_en = 1'b0;
    force u0.r_nops0 = 16'hFFFF;
    preload = 1'b1;
    @(posedge clk);
    #1;
    release u0.r_nops0;
    preload = 1'b0;
    cmp_en = 1'b1;
    @(negedge clk);
    chk("wrap_preload", nops0_o[0], 16'hFFFF);
    req0 = 1'b1; wr0 = 1'b0; addr0 = 16'h0002;
    wait_u0(0, 12, "wrap_ack0");
    req0 = 1'b0;
    chk("wrap_nops0", nops0_o[0], 16'h0000);
    chk("wrap_nops1", nops1_o[0], 16'h0000);
    repeat (12) @(negedge clk);

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      req0  = ($urandom_range(0, 3) != 0);
      req1  = ($urandom_range(0, 3) != 0);
      wr0   = $urandom_range(0, 1) == 1;
      wr1   = $urandom_range(0, 1) == 1;
      addr0 = 16'($urandom_range(0, 7));
      addr1 = 16'($urandom_range(0, 7));
      wd0   = 16'($urandom);
      wd1   = 16'($urandom);
      rst_n = ($urandom_range(0, 199) != 0);
    end
    @(negedge clk);
    rst_n = 1'b1; req0 = 1'b0; req1 = 1'b0;
    repeat (20) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
